game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level pong game-flow controller that sequences ball_controller and the score logic.
- Drives ball run/serve control from start-button and miss events, counting delays in timing_tick frame ticks.
- Keeps both scores and declares the winner.
- Sits between the input/debounce logic and ball_controller; its score/state outputs feed the VGA overlay.

Parameters:
- SERVE_DELAY, 60: timing_tick count spent in SERVE_WAIT before the ball moves (1..255).
- POINT_DELAY, 60: timing_tick count spent in POINT after a miss (1..255).
- WIN_SCORE, 9: score that ends the game (1..15).

Ports:
- clk  in  1  system clock, 65 MHz.
- rst  in  1  asynchronous reset, active-high.
- timing_tick  in  1  one-cycle frame tick from timing logic.
- start_btn  in  1  debounced start level; acts on rising edge only.
- miss_left  in  1  one-cycle pulse: ball passed the left pad.
- miss_right  in  1  one-cycle pulse: ball passed the right pad.
- ball_run  out  1  1 = ball_controller may move the ball.
- ball_serve  out  1  one-cycle pulse: reload ball to centre.
- serve_dir  out  1  0 = next serve travels left, 1 = right.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- state  out  3  encoded FSM state for display/debug.
- winner  out  1  0 = left won, 1 = right won; valid in GAME_OVER only.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE(0), ball_run=0, ball_serve=0, serve_dir=1, scores=0, winner=0, delay counter=0, start_btn edge register=0.
- Reset is asynchronous, and mid-game it aborts immediately to IDLE with all of the above values.
- start_rise = start_btn & ~start_btn_q, where start_btn_q is registered every clk.
- States and encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE:
  - ball_run=0.
  - On start_rise: clear both scores, set serve_dir=1, pulse ball_serve, go to SERVE_WAIT.
- SERVE_WAIT:
  - Delay counter clears on entry and increments on each timing_tick.
  - When counter==SERVE_DELAY-1 and timing_tick: go to PLAY; ball_run=1 from the next cycle.
  - Miss pulses are ignored here.
- PLAY: ball_run=1.
  - miss_left alone: score_right+1, serve_dir=0 (serve toward the conceding player), go to POINT.
  - miss_right alone: score_left+1, serve_dir=1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
  - start_rise is ignored.
- POINT:
  - ball_run=0 in the first cycle of POINT.
  - If either score == WIN_SCORE: go to GAME_OVER the next cycle, winner = (score_right==WIN_SCORE).
  - Otherwise wait POINT_DELAY ticks (same counting rule as SERVE_WAIT), then pulse ball_serve and go to SERVE_WAIT.
  - Miss pulses are ignored here.
- GAME_OVER:
  - ball_run=0; scores and winner hold.
  - On start_rise: behaves exactly as from IDLE (scores cleared, serve_dir=1, ball_serve pulse).
- ball_serve timing: high for exactly one clk, in the same cycle state first shows SERVE_WAIT.
- Score width rules: 4-bit; increments saturate at 15, though WIN_SCORE ≤ 15 makes this unreachable in a legal game.
- A timing_tick coincident with a state entry does not count toward the new state's delay.
- Latency from a miss pulse to the score update and state=POINT: 1 clk.

Test Plan (SERVE_DELAY=2, POINT_DELAY=3, WIN_SCORE=3):
- Reset then idle: assert rst for 2 cycles, release, hold start_btn=0 for 10 ticks -> state=0, ball_run=0, scores=0, no ball_serve pulse.
- Start and serve: start_btn rises -> next clk state=1 with ball_serve=1 for exactly 1 clk and serve_dir=1; after 2 timing_ticks -> state=2, ball_run=1.
- Left miss: miss_left pulse in PLAY -> next clk score_right=1, serve_dir=0, state=3, ball_run=0; after 3 ticks -> ball_serve pulse, state=1.
- Simultaneous misses: miss_left and miss_right in the same cycle -> state=3, both scores unchanged; misses during SERVE_WAIT/POINT ignored.
- Win and restart: 3 miss_right pulses across 3 rallies -> score_left=3, state=4, winner=0, ball_run=0; holding start_btn high does nothing; a new rising edge -> scores=0, state=1, ball_serve pulse.
- Async reset mid-PLAY: assert rst between clk edges with score_left=2 -> outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - pong game-flow controller: serve/point delays, scoring, winner
// Sequences ball_controller from start-button and miss events, counting delays in frame ticks.
module game_sequencer #(
   parameter int SERVE_DELAY = 60,
   parameter int POINT_DELAY = 60,
   parameter int WIN_SCORE   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timing_tick,
   input  logic       start_btn,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_run,
   output logic       ball_serve,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [2:0] state,
   output logic       winner
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      POINT      = 3'd3,
      GAME_OVER  = 3'd4
   } state_t;

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
   localparam logic [7:0] POINT_LAST = 8'(POINT_DELAY - 1);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);

   state_t     st;
   logic [7:0] delay_cnt;
   logic       start_btn_q;
   logic       start_rise;

   assign start_rise = start_btn & ~start_btn_q;
   assign state      = st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= IDLE;
         ball_run    <= 1'b0;
         ball_serve  <= 1'b0;
         serve_dir   <= 1'b1;
         score_left  <= 4'd0;
         score_right <= 4'd0;
         winner      <= 1'b0;
         delay_cnt   <= 8'd0;
         start_btn_q <= 1'b0;
      end else begin
         start_btn_q <= start_btn;
         ball_serve  <= 1'b0;
         case (st)
            IDLE, GAME_OVER: begin
               ball_run <= 1'b0;
               if (start_rise) begin
                  score_left  <= 4'd0;
                  score_right <= 4'd0;
                  serve_dir   <= 1'b1;
                  ball_serve  <= 1'b1;
                  delay_cnt   <= 8'd0;
                  st          <= SERVE_WAIT;
               end
            end
            SERVE_WAIT: begin
               if (timing_tick) begin
                  if (delay_cnt == SERVE_LAST) begin
                     st       <= PLAY;
                     ball_run <= 1'b1;
                  end else begin
                     delay_cnt <= delay_cnt + 8'd1;
                  end
               end
            end
            PLAY: begin
               ball_run <= 1'b1;
               if (miss_left || miss_right) begin
                  ball_run  <= 1'b0;
                  delay_cnt <= 8'd0;
                  st        <= POINT;
                  // a double miss is a replay: neither score nor serve side moves
                  if (miss_left && !miss_right) begin
                     if (score_right != 4'd15) score_right <= score_right + 4'd1;
                     serve_dir <= 1'b0;
                  end else if (miss_right && !miss_left) begin
                     if (score_left != 4'd15) score_left <= score_left + 4'd1;
                     serve_dir <= 1'b1;
                  end
               end
            end
            POINT: begin
               ball_run <= 1'b0;
               if (score_left == WIN || score_right == WIN) begin
                  winner <= (score_right == WIN);
                  st     <= GAME_OVER;
               end else if (timing_tick) begin
                  if (delay_cnt == POINT_LAST) begin
                     ball_serve <= 1'b1;
                     delay_cnt  <= 8'd0;
                     st         <= SERVE_WAIT;
                  end else begin
                     delay_cnt <= delay_cnt + 8'd1;
                  end
               end
            end
            default: begin
               ball_run <= 1'b0;
               st       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
// Directed scenarios plus randomized traffic against a tick-countdown reference model.
module tb_game_sequencer;

   localparam int SD = 2;
   localparam int PD = 3;
   localparam int W  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       timing_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       miss_left = 1'b0;
   logic       miss_right = 1'b0;
   logic       ball_run, ball_serve, serve_dir, winner;
   logic [3:0] score_left, score_right;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: game phase, scores and remaining ticks in the current wait
   int m_state, m_sl, m_sr, m_ticks_left;
   bit m_run, m_serve, m_dir, m_win, m_prev_btn;

   game_sequencer #(.SERVE_DELAY(SD), .POINT_DELAY(PD), .WIN_SCORE(W)) dut (
      .clk(clk), .rst(rst), .timing_tick(timing_tick), .start_btn(start_btn),
      .miss_left(miss_left), .miss_right(miss_right), .ball_run(ball_run),
      .ball_serve(ball_serve), .serve_dir(serve_dir), .score_left(score_left),
      .score_right(score_right), .state(state), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_sl = 0; m_sr = 0; m_ticks_left = 0;
      m_run = 0; m_serve = 0; m_dir = 1; m_win = 0; m_prev_btn = 0;
   endtask

   task automatic model_step(input bit t, input bit b, input bit l, input bit r);
      bit rise;
      rise = b && !m_prev_btn;
      m_prev_btn = b;
      m_serve = 0;
      case (m_state)
         0, 4: begin
            m_run = 0;
            if (rise) begin
               m_sl = 0; m_sr = 0; m_dir = 1; m_serve = 1;
               m_state = 1; m_ticks_left = SD;
            end
         end
         1: if (t) begin
            m_ticks_left--;
            if (m_ticks_left == 0) begin m_state = 2; m_run = 1; end
         end
         2: begin
            m_run = 1;
            if (l || r) begin
               m_state = 3; m_run = 0; m_ticks_left = PD;
               if (l && !r) begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_dir = 0; end
               if (r && !l) begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_dir = 1; end
            end
         end
         default: begin
            m_run = 0;
            if (m_sl == W || m_sr == W) begin
               m_state = 4; m_win = (m_sr == W);
            end else if (t) begin
               m_ticks_left--;
               if (m_ticks_left == 0) begin m_serve = 1; m_state = 1; m_ticks_left = SD; end
            end
         end
      endcase
   endtask

   task automatic cycle(input bit t, input bit b, input bit l, input bit r);
      timing_tick = t; start_btn = b; miss_left = l; miss_right = r;
      @(posedge clk);
      model_step(t, b, l, r);
      #1;
      timing_tick = 0; miss_left = 0; miss_right = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, start_btn, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (state !== 3'd0 || ball_run !== 1'b0 || ball_serve !== 1'b0 || serve_dir !== 1'b1 ||
          score_left !== 4'd0 || score_right !== 4'd0 || winner !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: state=%0d run=%b serve=%b dir=%b sl=%0d sr=%0d win=%b, want 0 0 0 1 0 0 0",
                  state, ball_run, ball_serve, serve_dir, score_left, score_right, winner);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         n_tests++;
         if (state !== 3'd0 || ball_run !== 1'b0 || ball_serve !== 1'b0 ||
             score_left !== 4'd0 || score_right !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: state=%0d run=%b serve=%b sl=%0d sr=%0d, want all 0",
                     i, state, ball_run, ball_serve, score_left, score_right);
         end
      end
   endtask

   task automatic test_start_serve();
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd1 || ball_serve !== 1'b1 || serve_dir !== 1'b1 || ball_run !== 1'b0) begin
         n_fail++;
         $display("FAIL start_serve: state=%0d serve=%b dir=%b run=%b, want 1 1 1 0",
                  state, ball_serve, serve_dir, ball_run);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd1 || ball_serve !== 1'b0) begin
         n_fail++;
         $display("FAIL serve_pulse_width: state=%0d serve=%b, want 1 0", state, ball_serve);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd2 || ball_run !== 1'b1) begin
         n_fail++;
         $display("FAIL serve_to_play: state=%0d run=%b, want 2 1", state, ball_run);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_left_miss();
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (state !== 3'd3 || score_right !== 4'd1 || score_left !== 4'd0 ||
          serve_dir !== 1'b0 || ball_run !== 1'b0) begin
         n_fail++;
         $display("FAIL left_miss: state=%0d sr=%0d sl=%0d dir=%b run=%b, want 3 1 0 0 0",
                  state, score_right, score_left, serve_dir, ball_run);
      end
      ticks(PD - 1);
      n_tests++;
      if (state !== 3'd3 || ball_serve !== 1'b0) begin
         n_fail++;
         $display("FAIL point_early: state=%0d serve=%b, want 3 0", state, ball_serve);
      end
      ticks(1);
      n_tests++;
      if (state !== 3'd1 || ball_serve !== 1'b1 || serve_dir !== 1'b0) begin
         n_fail++;
         $display("FAIL point_to_serve: state=%0d serve=%b dir=%b, want 1 1 0",
                  state, ball_serve, serve_dir);
      end
   endtask

   task automatic test_simultaneous();
      ticks(SD);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      n_tests++;
      if (state !== 3'd3 || score_left !== 4'd0 || score_right !== 4'd1 || serve_dir !== 1'b0) begin
         n_fail++;
         $display("FAIL double_miss: state=%0d sl=%0d sr=%0d dir=%b, want 3 0 1 0",
                  state, score_left, score_right, serve_dir);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (state !== 3'd3 || score_left !== 4'd0 || score_right !== 4'd1) begin
         n_fail++;
         $display("FAIL miss_in_point: state=%0d sl=%0d sr=%0d, want 3 0 1",
                  state, score_left, score_right);
      end
      ticks(PD);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (state !== 3'd1 || score_left !== 4'd0 || score_right !== 4'd1) begin
         n_fail++;
         $display("FAIL miss_in_serve_wait: state=%0d sl=%0d sr=%0d, want 1 0 1",
                  state, score_left, score_right);
      end
      ticks(SD);
   endtask

   task automatic test_win_restart();
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd2 || ball_serve !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_play: state=%0d serve=%b, want 2 0", state, ball_serve);
      end
      for (int k = 1; k <= W; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b1);
         if (k < W) begin
            ticks(PD);
            ticks(SD);
         end
      end
      n_tests++;
      if (state !== 3'd3 || score_left !== 4'd3 || serve_dir !== 1'b1) begin
         n_fail++;
         $display("FAIL final_point: state=%0d sl=%0d dir=%b, want 3 3 1", state, score_left, serve_dir);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd4 || winner !== 1'b0 || ball_run !== 1'b0 || score_left !== 4'd3) begin
         n_fail++;
         $display("FAIL game_over: state=%0d win=%b run=%b sl=%0d, want 4 0 0 3",
                  state, winner, ball_run, score_left);
      end
      ticks(5);
      n_tests++;
      if (state !== 3'd4 || ball_serve !== 1'b0 || score_left !== 4'd3 || score_right !== 4'd1) begin
         n_fail++;
         $display("FAIL held_btn_over: state=%0d serve=%b sl=%0d sr=%0d, want 4 0 3 1",
                  state, ball_serve, score_left, score_right);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (state !== 3'd1 || ball_serve !== 1'b1 || serve_dir !== 1'b1 ||
          score_left !== 4'd0 || score_right !== 4'd0) begin
         n_fail++;
         $display("FAIL restart: state=%0d serve=%b dir=%b sl=%0d sr=%0d, want 1 1 1 0 0",
                  state, ball_serve, serve_dir, score_left, score_right);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2; k++) begin
         ticks(SD);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         ticks(PD);
      end
      ticks(SD);
      n_tests++;
      if (state !== 3'd2 || score_left !== 4'd2) begin
         n_fail++;
         $display("FAIL pre_reset_play: state=%0d sl=%0d, want 2 2", state, score_left);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (state !== 3'd0 || ball_run !== 1'b0 || ball_serve !== 1'b0 || serve_dir !== 1'b1 ||
          score_left !== 4'd0 || score_right !== 4'd0 || winner !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: state=%0d run=%b serve=%b dir=%b sl=%0d sr=%0d win=%b, want 0 0 0 1 0 0 0",
                  state, ball_run, ball_serve, serve_dir, score_left, score_right, winner);
      end
      model_reset();
      start_btn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [14:0] got, want;
      bit b, l, r;
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) b = ~b;
         l = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 5) == 0);
         cycle(1'($urandom_range(0, 1)), b, l, r);
         want = {3'(m_state), m_run, m_serve, m_dir, 4'(m_sl), 4'(m_sr), (m_state == 4) ? m_win : 1'b0};
         got  = {state, ball_run, ball_serve, serve_dir, score_left, score_right,
                 (m_state == 4) ? winner : 1'b0};
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL random[%0d]: got st/run/srv/dir/sl/sr/win=%0d %b %b %b %0d %0d %b, want %0d %b %b %b %0d %0d %b",
                     i, got[14:12], got[11], got[10], got[9], got[8:5], got[4:1], got[0],
                     want[14:12], want[11], want[10], want[9], want[8:5], want[4:1], want[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_serve();
      test_left_miss();
      test_simultaneous();
      test_win_restart();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
